// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the adder scheduler: FSM encoding, requester
// count default and result-id width.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = 2;
  localparam int ADDER_W   = 32;

endpackage

// File: rtl/adder.sv
// Shared 32-bit adder: eight 4-bit carry-lookahead slices with the group
// carry of each slice feeding the next.
module Adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  for (genvar s = 0; s < 8; s++) begin : g_slice
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] ci;
    logic       c_in;
    logic       c_out;

    if (s == 0) begin : g_first
      assign c_in = cin;
    end else begin : g_chain
      assign c_in = g_slice[s-1].c_out;
    end

    assign g     = a[4*s +: 4] & b[4*s +: 4];
    assign p     = a[4*s +: 4] ^ b[4*s +: 4];
    assign ci[0] = c_in;
    assign ci[1] = g[0] | (p[0] & c_in);
    assign ci[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign ci[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c_in);
    assign sum[4*s +: 4] = p ^ ci;
  end

  assign cout = g_slice[7].c_out;

endmodule

// File: rtl/adder_scheduler_rr_pick.sv
// Combinational round-robin picker: the first active request at or after ptr
// (with wrap) wins.
module rr_pick
  import adder_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  logic [ID_W-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx  = '0;
    cand = '0;
    // Walk from the farthest offset down so the closest hit to ptr wins.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = ID_W'((int'(ptr) + off) % N_REQ);
      if (req[cand]) idx = cand;
    end
    found = |req;
    gnt   = '0;
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/adder_scheduler.sv
// Round-robin scheduler sharing one Adder among N_REQ requesters.
// Optional ADDER_SCHED_STATS_EN adds a saturating accepted-result counter op_count.
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = ADDER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_flat,
  input  logic [N_REQ*W-1:0] b_flat,
  input  logic [N_REQ-1:0]   cin,
  input  logic [N_REQ-1:0]   sub,
  output logic [N_REQ-1:0]   gnt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_id,
  output logic [W-1:0]       res_sum,
  output logic               res_cout,
  output logic               res_ovf
`ifdef ADDER_SCHED_STATS_EN
  , output logic [15:0]      op_count
`endif
);

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  logic            grant_ok;

  logic [W-1:0]    sel_a, sel_b;
  logic            sel_cin, sel_sub;
  logic [W-1:0]    op_a, op_b;
  logic            op_c;
  logic [ID_W-1:0] op_id;
  logic [W-1:0]    add_sum;
  logic            add_cout;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  Adder u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_c),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign grant_ok  = !rst && pick_found && (state == IDLE || (state == RESP && res_ready));
  assign gnt       = grant_ok ? pick_gnt : '0;
  assign res_valid = (state == RESP);

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    sel_sub = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_a   = a_flat[i*W +: W];
        sel_b   = b_flat[i*W +: W];
        sel_cin = cin[i];
        sel_sub = sub[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ok) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = grant_ok ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      res_id   <= '0;
      res_sum  <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_ok) ptr <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      if (state == EXEC) begin
        res_id   <= op_id;
        res_sum  <= add_sum;
        res_cout <= add_cout;
        res_ovf  <= (op_a[W-1] == op_b[W-1]) && (add_sum[W-1] != op_a[W-1]);
      end
    end
  end

  // NOTE: operand registers carry no reset; they are only read in EXEC, which is reached solely via a grant that loads them.
  always_ff @(posedge clk) begin
    if (grant_ok) begin
      op_a  <= sel_a;
      op_b  <= sel_sub ? ~sel_b : sel_b;
      op_c  <= sel_sub ? 1'b1 : sel_cin;
      op_id <= pick_idx;
    end
  end

`ifdef ADDER_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) op_count <= '0;
    else if (res_valid && res_ready && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end
`endif

endmodule
